// File: rtl/fetch_prefetch.sv
// Instruction-fetch front end: owns the fetch PC, issues word reads to a 1-cycle synchronous ROM,
// and queues {pc, instr} pairs for the core. Optional counters are enabled with `define FETCH_STATS_EN.
module fetch_prefetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] stat_fetch_cnt,
  output logic [31:0] stat_kill_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;

  state_t          state_reg, state_next;
  logic [31:0]     fetch_pc_reg;
  logic            resp_live_reg;
  logic [31:0]     resp_pc_reg;
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic [31:0]     pc_mem    [DEPTH];
  logic [31:0]     instr_mem [DEPTH];

  logic            fifo_empty;
  logic [CW-1:0]   occupancy;
  logic            credit_ok;
  logic            head_valid;
  logic            pop;
  logic            fifo_pop;
  logic            fifo_push;

  // The returning ROM word counts as occupancy and is visible as head before it is stored.
  assign fifo_empty = (count_reg == '0);
  assign occupancy  = count_reg + CW'(resp_live_reg);
  assign credit_ok  = (occupancy < CW'(DEPTH));
  assign head_valid = !fifo_empty || resp_live_reg;
  assign pop        = head_valid && out_ready && !redirect;
  assign fifo_pop   = pop && !fifo_empty;
  assign fifo_push  = resp_live_reg && !redirect && !(pop && fifo_empty);

  // FSM state register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // FSM next-state logic
  always_comb begin
    state_next = state_reg;
    if (redirect) begin
      state_next = FLUSH;
    end else begin
      case (state_reg)
        IDLE:    state_next = RUN;
        RUN:     state_next = RUN;
        FLUSH:   state_next = RUN;
        default: state_next = IDLE;
      endcase
    end
  end

  // FSM / datapath outputs
  always_comb begin
    imem_req  = (state_reg == RUN) && credit_ok;
    imem_addr = fetch_pc_reg;
    out_valid = head_valid;
    out_pc    = 32'h0;
    out_instr = 32'h0;
    if (!fifo_empty) begin
      out_pc    = pc_mem[rd_ptr_reg];
      out_instr = instr_mem[rd_ptr_reg];
    end else if (resp_live_reg) begin
      out_pc    = resp_pc_reg;
      out_instr = imem_rdata;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      fetch_pc_reg  <= RESET_PC;
      resp_live_reg <= 1'b0;
      resp_pc_reg   <= 32'h0;
    end else begin
      // A request issued in the redirect cycle is never marked live, so its data is dropped.
      resp_live_reg <= imem_req && !redirect;
      resp_pc_reg   <= fetch_pc_reg;
      if (redirect)      fetch_pc_reg <= redirect_pc & 32'hFFFF_FFFC;
      else if (imem_req) fetch_pc_reg <= fetch_pc_reg + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (redirect) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (fifo_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (fifo_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + CW'(fifo_push) - CW'(fifo_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_push) begin
      pc_mem[wr_ptr_reg]    <= resp_pc_reg;
      instr_mem[wr_ptr_reg] <= imem_rdata;
    end
  end

`ifdef FETCH_STATS_EN
  logic [32:0] kill_sum;
  assign kill_sum = {1'b0, stat_kill_cnt} + 33'(occupancy) + 33'(imem_req);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      stat_fetch_cnt <= 32'h0;
      stat_kill_cnt  <= 32'h0;
    end else begin
      if (imem_req && stat_fetch_cnt != 32'hFFFF_FFFF)
        stat_fetch_cnt <= stat_fetch_cnt + 32'd1;
      if (redirect)
        stat_kill_cnt <= kill_sum[32] ? 32'hFFFF_FFFF : kill_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_fetch_prefetch.sv
// Bench for fetch_prefetch: directed scenarios plus random ready/redirect traffic,
// checked every cycle against a queue-based model of the fetch rules.
module tb_fetch_prefetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 4;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetch_cnt;
  logic [31:0] stat_kill_cnt;
`endif

  fetch_prefetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetch_cnt (stat_fetch_cnt),
    .stat_kill_cnt  (stat_kill_cnt)
`endif
  );

  always #5 clk = ~clk;

  // ROM[i] = i, one-cycle registered read
  always @(posedge clk) if (imem_req) imem_rdata <= imem_addr >> 2;

  int tests = 0;
  int fails = 0;

  // Reference model: queue holds PCs of every fetched word not yet consumed or flushed.
  logic [31:0] m_q[$];
  logic [31:0] m_pc;
  bit          m_hold;
  longint      m_fetch_cnt;
  longint      m_kill_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc        = RESET_PC;
    m_hold      = 1'b1;
    m_fetch_cnt = 0;
    m_kill_cnt  = 0;
  endtask

  task automatic step(input logic rd, input logic [31:0] rpc, input logic rdy, input logic rst_n_val);
    logic        e_req;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    @(negedge clk);
    n_rst       = rst_n_val;
    redirect    = rd;
    redirect_pc = rpc;
    out_ready   = rdy;
    #1;
    if (!n_rst) model_reset();
    e_req   = (!m_hold && m_q.size() < DEPTH);
    e_valid = (m_q.size() > 0);
    e_pc    = e_valid ? m_q[0] : 32'h0;
    e_instr = e_valid ? (m_q[0] >> 2) : 32'h0;
    chk("imem_req",  {31'b0, imem_req},  {31'b0, e_req});
    chk("imem_addr", imem_addr, m_pc);
    chk("out_valid", {31'b0, out_valid}, {31'b0, e_valid});
    chk("out_pc",    out_pc,    e_pc);
    chk("out_instr", out_instr, e_instr);
`ifdef FETCH_STATS_EN
    chk("stat_fetch_cnt", stat_fetch_cnt, 32'(m_fetch_cnt));
    chk("stat_kill_cnt",  stat_kill_cnt,  32'(m_kill_cnt));
`endif
    if (n_rst) begin
      if (e_req) m_fetch_cnt = (m_fetch_cnt >= 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_fetch_cnt + 1;
      if (rd) begin
        m_kill_cnt = m_kill_cnt + m_q.size() + (e_req ? 1 : 0);
        if (m_kill_cnt > 64'hFFFF_FFFF) m_kill_cnt = 64'hFFFF_FFFF;
        $display("[TB] redirect to %h, discarded %0d", rpc & 32'hFFFF_FFFC, m_q.size() + (e_req ? 1 : 0));
        m_q.delete();
        m_pc   = rpc & 32'hFFFF_FFFC;
        m_hold = 1'b1;
      end else begin
        if (e_valid && rdy) begin
          $display("[TB] pop pc=%h instr=%h", m_q[0], m_q[0] >> 2);
          void'(m_q.pop_front());
        end
        if (e_req) begin
          m_q.push_back(m_pc);
          m_pc = m_pc + 32'd4;
        end
        m_hold = 1'b0;
      end
    end
  endtask

  initial begin
    model_reset();
    // Reset, then stream with out_ready=1
    step(0, 32'h0, 1, 0);
    step(0, 32'h0, 1, 0);
    for (int i = 0; i < 8; i++) step(0, 32'h0, 1, 1);

    // Fill with out_ready=0 from reset, then drain
    step(0, 32'h0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 32'h0, 0, 1);
    for (int i = 0; i < 6; i++) step(0, 32'h0, 1, 1);

    // Redirect with three entries queued and one request in flight
    step(0, 32'h0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 32'h0, 0, 1);
    step(1, 32'h0000_0040, 0, 1);
    for (int i = 0; i < 5; i++) step(0, 32'h0, 1, 1);

    // Misaligned target, back-to-back redirects, and address wrap
    step(1, 32'h0000_0103, 1, 1);
    for (int i = 0; i < 4; i++) step(0, 32'h0, 1, 1);
    step(1, 32'h0000_0200, 1, 1);
    step(1, 32'h0000_0300, 1, 1);
    for (int i = 0; i < 4; i++) step(0, 32'h0, 1, 1);
    step(1, 32'hFFFF_FFF8, 1, 1);
    for (int i = 0; i < 6; i++) step(0, 32'h0, 1, 1);

    // Random ready / redirect traffic
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 15) == 0), $urandom, ($urandom_range(0, 3) != 0), 1);

    // Reset mid-stream with a request in flight
    for (int i = 0; i < 3; i++) step(0, 32'h0, 1, 1);
    step(0, 32'h0, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 32'h0, 1, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
